// File: rtl/fifo_rd_stream.sv
// Read-side output stage of the async FIFO: turns empty/rd_en/sync-RAM pops into a valid/ready stream.
// 2-entry prefetch buffer with a pop credit that includes the in-flight word; 2 cycles from pop to stream valid.
module fifo_rd_stream #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  i_rd_clk,
   input  logic                  i_rst,
   input  logic                  i_empty_flag,
   output logic                  o_rd_en,
   input  logic [DATA_WIDTH-1:0] i_rd_data,
   output logic [DATA_WIDTH-1:0] o_m_data,
   output logic                  o_m_valid,
   input  logic                  i_m_ready,
   output logic [1:0]            o_level
);

   logic [1:0]            count_q, count_d;
   logic                  inflight_q;
   logic [DATA_WIDTH-1:0] head_q, head_d;
   logic [DATA_WIDTH-1:0] tail_q, tail_d;
   logic                  out_fire;
   logic [2:0]            credit_used;

   assign o_m_valid = (count_q != 2'd0);
   assign o_m_data  = head_q;
   assign o_level   = count_q;
   assign out_fire  = o_m_valid & i_m_ready;

   // A word leaving this cycle frees its slot in time for a pop issued now.
   assign credit_used = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, out_fire};
   assign o_rd_en     = !i_rst && !i_empty_flag && (credit_used < 3'd2);

   always_comb begin
      count_d = count_q;
      head_d  = head_q;
      tail_d  = tail_q;
      case ({inflight_q, out_fire})
         2'b10: begin
            if (count_q == 2'd0) begin
               head_d  = i_rd_data;
               count_d = 2'd1;
            end else begin
               tail_d  = i_rd_data;
               count_d = 2'd2;
            end
         end
         2'b01: begin
            head_d  = tail_q;
            count_d = count_q - 2'd1;
         end
         2'b11: begin
            // Count is unchanged; the arrival lands behind whatever remains.
            if (count_q == 2'd1) begin
               head_d = i_rd_data;
            end else begin
               head_d = tail_q;
               tail_d = i_rd_data;
            end
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge i_rd_clk) begin
      if (i_rst) begin
         count_q    <= 2'd0;
         inflight_q <= 1'b0;
         head_q     <= '0;
         tail_q     <= '0;
      end else begin
         count_q    <= count_d;
         inflight_q <= o_rd_en;
         head_q     <= head_d;
         tail_q     <= tail_d;
      end
   end

endmodule
